// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB request arbiter.
// Optional watchdog in apb_req_arbiter is enabled with APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Minimum width 1 so that single-valued ranges still produce a legal vector.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) bits++;
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant, with wrap.
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic            valid,
    output logic [IW-1:0]   index
);

    always_comb begin
        int unsigned cand;
        valid = 1'b0;
        index = '0;
        cand  = 0;
        // Scan farthest offset first so the nearest requester after last_grant overwrites.
        for (int unsigned off = NREQ; off >= 1; off--) begin
            cand = (32'(last_grant) + off) % NREQ;
            if (req[IW'(cand)]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master between NREQ command sources.
// Define APB_ARB_TIMEOUT_EN to enable the XFER watchdog (TIMEOUT cycles).
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DW-1:0]            rsp_rdata,
    output logic                     rsp_err,
    output logic                     Transfer,
    output logic                     Read_Write,
    output logic [AW-1:0]            apb_write_paddr,
    output logic [DW-1:0]            apb_write_data,
    output logic [AW-1:0]            apb_read_paddr,
    input  logic                     apb_done,
    input  logic [DW-1:0]            apb_rdata,
    input  logic                     apb_slverr,
    output logic                     busy,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     timeout
);

    localparam int unsigned IW = clog2(NREQ);

    arb_state_t      state;
    logic [IW-1:0]   last_grant;
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic            sel_write;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            wd_expired;

    apb_rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        sel_write = req_write[pick_idx];
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TW = clog2(TIMEOUT + 1);

    logic [TW-1:0] wd_cnt;

    // wd_cnt counts completed XFER cycles; this cycle is the TIMEOUT-th one.
    assign wd_expired = (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= (state == XFER) && !apb_done && wd_expired;
            if (state != XFER) wd_cnt <= '0;
            else               wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout    = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state           <= IDLE;
            last_grant      <= IW'(NREQ - 1);
            grant_id        <= '0;
            req_ready       <= '0;
            rsp_valid       <= '0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            Transfer        <= 1'b0;
            Read_Write      <= RW_READ;
            apb_write_paddr <= '0;
            apb_write_data  <= '0;
            apb_read_paddr  <= '0;
            busy            <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state           <= XFER;
                        busy            <= 1'b1;
                        grant_id        <= pick_idx;
                        req_ready       <= NREQ'(1) << pick_idx;
                        Read_Write      <= sel_write ? RW_WRITE : RW_READ;
                        apb_write_paddr <= sel_write ? sel_addr  : '0;
                        apb_write_data  <= sel_write ? sel_wdata : '0;
                        apb_read_paddr  <= sel_write ? '0 : sel_addr;
                    end
                end
                XFER: begin
                    if (apb_done) begin
                        state     <= RESP;
                        Transfer  <= 1'b0;
                        rsp_valid <= NREQ'(1) << grant_id;
                        rsp_rdata <= (Read_Write == RW_WRITE) ? '0 : apb_rdata;
                        rsp_err   <= apb_slverr;
                    end else if (wd_expired) begin
                        state     <= RESP;
                        Transfer  <= 1'b0;
                        rsp_valid <= NREQ'(1) << grant_id;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else begin
                        Transfer <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    last_grant <= grant_id;
                    rsp_rdata  <= '0;
                    rsp_err    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter (NREQ=4, TIMEOUT=8), random stimulus vs transaction model.
module tb_apb_req_arbiter;

    logic         PCLK = 1'b0;
    logic         PRESET;
    logic [3:0]   req_valid, req_write;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]   req_ready, rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err, Transfer, Read_Write;
    logic [31:0]  apb_write_paddr, apb_write_data, apb_read_paddr;
    logic         apb_done;
    logic [31:0]  apb_rdata;
    logic         apb_slverr;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout;

    int total = 0;
    int bad   = 0;
    int exp_last;

    apb_req_arbiter #(
        .NREQ    (4),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .PCLK            (PCLK),
        .PRESET          (PRESET),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .Transfer        (Transfer),
        .Read_Write      (Read_Write),
        .apb_write_paddr (apb_write_paddr),
        .apb_write_data  (apb_write_data),
        .apb_read_paddr  (apb_read_paddr),
        .apb_done        (apb_done),
        .apb_rdata       (apb_rdata),
        .apb_slverr      (apb_slverr),
        .busy            (busy),
        .grant_id        (grant_id),
        .timeout         (timeout)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_write[i]       = w;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // Reference round-robin rule: first valid requester after 'last', wrapping.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= 4; off++) begin
            int idx;
            idx = (last + off) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic do_reset();
        PRESET = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;
        exp_last = 3;
    endtask

    task automatic test_reset();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        apb_done = 1'b0; apb_rdata = '0; apb_slverr = 1'b0;
        do_reset();
        total++; if ({req_ready, rsp_valid} !== 8'h00) begin bad++; $display("FAIL reset_handshake got=%h exp=00", {req_ready, rsp_valid}); end
        total++; if ({rsp_err, Transfer, Read_Write, busy, timeout} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=00000", {rsp_err, Transfer, Read_Write, busy, timeout}); end
        total++; if ({rsp_rdata, apb_write_paddr, apb_write_data, apb_read_paddr} !== 128'h0) begin bad++; $display("FAIL reset_buses got=%h exp=0", {rsp_rdata, apb_write_paddr, apb_write_data, apb_read_paddr}); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    endtask

    task automatic test_single_read();
        set_cmd(2, 1'b0, 32'h10, 32'h0);
        req_valid = 4'b0100;
        tick();
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL rd_ready got=%b exp=0100", req_ready); end
        total++; if ({Transfer, busy, grant_id} !== 4'b0110) begin bad++; $display("FAIL rd_accept_state got=%b exp=0110", {Transfer, busy, grant_id}); end
        req_valid = '0;
        tick();
        total++; if ({Transfer, Read_Write, req_ready} !== 6'b100000) begin bad++; $display("FAIL rd_transfer got=%b exp=100000", {Transfer, Read_Write, req_ready}); end
        total++; if ({apb_read_paddr, apb_write_paddr} !== {32'h10, 32'h0}) begin bad++; $display("FAIL rd_addr got=%h exp=%h", {apb_read_paddr, apb_write_paddr}, {32'h10, 32'h0}); end
        tick();
        tick();
        apb_done = 1'b1; apb_rdata = 32'hA5A5_0001;
        tick();
        apb_done = 1'b0;
        total++; if ({rsp_valid, Transfer} !== 5'b01000) begin bad++; $display("FAIL rd_rsp_valid got=%b exp=01000", {rsp_valid, Transfer}); end
        total++; if ({rsp_rdata, rsp_err} !== {32'hA5A5_0001, 1'b0}) begin bad++; $display("FAIL rd_rsp_data got=%h exp=%h", {rsp_rdata, rsp_err}, {32'hA5A5_0001, 1'b0}); end
        tick();
        total++; if ({rsp_valid, busy} !== 5'b0) begin bad++; $display("FAIL rd_idle got=%b exp=00000", {rsp_valid, busy}); end
        exp_last = 2;
    endtask

    task automatic test_write();
        set_cmd(0, 1'b1, 32'h04, 32'hDEAD_BEEF);
        req_valid = 4'b0001;
        tick();
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got=%b exp=0001", req_ready); end
        req_valid = '0;
        set_cmd(0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if ({Transfer, Read_Write, apb_write_paddr, apb_write_data, apb_read_paddr} !== {2'b11, 32'h04, 32'hDEAD_BEEF, 32'h0}) begin
                bad++; $display("FAIL wr_hold cyc=%0d got=%h exp=%h", c, {Transfer, Read_Write, apb_write_paddr, apb_write_data, apb_read_paddr}, {2'b11, 32'h04, 32'hDEAD_BEEF, 32'h0});
            end
        end
        apb_done = 1'b1; apb_rdata = 32'h5555_AAAA;
        tick();
        apb_done = 1'b0;
        total++; if ({rsp_valid, rsp_rdata, rsp_err} !== {4'b0001, 32'h0, 1'b0}) begin bad++; $display("FAIL wr_rsp got=%h exp=%h", {rsp_valid, rsp_rdata, rsp_err}, {4'b0001, 32'h0, 1'b0}); end
        tick();
        exp_last = 0;
    endtask

    task automatic test_slverr();
        set_cmd(1, 1'b0, 32'h20, 32'h0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        apb_done = 1'b1; apb_slverr = 1'b1; apb_rdata = 32'h0BAD_0BAD;
        tick();
        apb_done = 1'b0; apb_slverr = 1'b0;
        total++; if ({rsp_valid, rsp_err} !== 5'b00101) begin bad++; $display("FAIL slverr_rsp got=%b exp=00101", {rsp_valid, rsp_err}); end
        tick();
        total++; if ({rsp_valid, rsp_err} !== 5'b0) begin bad++; $display("FAIL slverr_clear got=%b exp=00000", {rsp_valid, rsp_err}); end
        exp_last = 1;
    endtask

    task automatic test_rr_all();
        int order[5] = '{0, 1, 2, 3, 0};
        int grants, overlap, cyc, dcount, g;
        logic outstanding;
        do_reset();
        req_valid = 4'hF;
        grants = 0; overlap = 0; cyc = 0; dcount = 1; outstanding = 1'b0;
        while ((grants < 5 || outstanding) && cyc < 100) begin
            tick();
            cyc++;
            apb_done = 1'b0;
            if (req_ready != 4'b0) begin
                g = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                if (outstanding) overlap++;
                total++; if (g !== order[grants] || req_ready !== (4'b1 << order[grants])) begin
                    bad++; $display("FAIL rr_order n=%0d got=%b exp_idx=%0d", grants, req_ready, order[grants]);
                end
                outstanding = 1'b1;
                grants++;
            end
            if (rsp_valid != 4'b0) outstanding = 1'b0;
            if (Transfer === 1'b1) begin
                if (dcount == 0) begin apb_done = 1'b1; apb_rdata = $urandom; dcount = $urandom_range(0, 2); end
                else dcount--;
            end
        end
        req_valid = '0;
        apb_done = 1'b0;
        total++; if (grants !== 5 || outstanding) begin bad++; $display("FAIL rr_progress got=%0d exp=5", grants); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL rr_overlap got=%0d exp=0", overlap); end
        tick();
        exp_last = 0;
    endtask

    task automatic test_random();
        logic [3:0]  mask;
        logic [31:0] rd, ea, ed;
        logic        w, err;
        int          exp_g;
        for (int t = 0; t < 40; t++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) set_cmd(i, 1'($urandom), $urandom, $urandom);
            req_valid = mask;
            if (t % 5 == 0) begin apb_done = 1'b1; apb_rdata = $urandom; end
            exp_g = rr_pick(mask, exp_last);
            w  = req_write[exp_g];
            ea = req_addr[exp_g*32 +: 32];
            ed = req_wdata[exp_g*32 +: 32];
            tick();
            apb_done = 1'b0;
            total++; if ({req_ready, rsp_valid, grant_id} !== {4'b1 << exp_g, 4'b0, 2'(exp_g)}) begin
                bad++; $display("FAIL rand_grant t=%0d got=%h exp=%h", t, {req_ready, rsp_valid, grant_id}, {4'b1 << exp_g, 4'b0, 2'(exp_g)});
            end
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) set_cmd(i, 1'($urandom), $urandom, $urandom);
            tick();
            total++; if ({Transfer, Read_Write, apb_write_paddr, apb_write_data, apb_read_paddr, req_ready} !==
                         {1'b1, w, w ? ea : 32'h0, w ? ed : 32'h0, w ? 32'h0 : ea, 4'b0}) begin
                bad++; $display("FAIL rand_bus t=%0d got=%h exp=%h", t, {Transfer, Read_Write, apb_write_paddr, apb_write_data, apb_read_paddr},
                                {1'b1, w, w ? ea : 32'h0, w ? ed : 32'h0, w ? 32'h0 : ea});
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                total++; if ({req_ready, rsp_valid, Transfer} !== 9'b000000001) begin bad++; $display("FAIL rand_holdoff t=%0d got=%b exp=000000001", t, {req_ready, rsp_valid, Transfer}); end
            end
            rd = $urandom; err = 1'($urandom);
            apb_done = 1'b1; apb_rdata = rd; apb_slverr = err;
            tick();
            apb_done = 1'b0; apb_slverr = 1'b0;
            total++; if ({rsp_valid, rsp_rdata, rsp_err, Transfer, req_ready} !== {4'b1 << exp_g, w ? 32'h0 : rd, err, 1'b0, 4'b0}) begin
                bad++; $display("FAIL rand_rsp t=%0d got=%h exp=%h", t, {rsp_valid, rsp_rdata, rsp_err, Transfer, req_ready}, {4'b1 << exp_g, w ? 32'h0 : rd, err, 1'b0, 4'b0});
            end
            exp_last = exp_g;
            tick();
            total++; if ({rsp_valid, req_ready, busy} !== 9'b0) begin bad++; $display("FAIL rand_idle t=%0d got=%b exp=000000000", t, {rsp_valid, req_ready, busy}); end
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        set_cmd(3, 1'b1, 32'h30, 32'h3333);
        req_valid = 4'b1000;
        tick();
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1000", req_ready); end
        req_valid = '0;
        tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        total++; if ({Transfer, busy, rsp_valid, grant_id} !== 8'b0) begin bad++; $display("FAIL rst_mid_abort got=%b exp=00000000", {Transfer, busy, rsp_valid, grant_id}); end
        apb_done = 1'b1;
        tick();
        apb_done = 1'b0;
        tick();
        total++; if ({rsp_valid, busy} !== 5'b0) begin bad++; $display("FAIL rst_mid_norsp got=%b exp=00000", {rsp_valid, busy}); end
        exp_last = 3;
        set_cmd(0, 1'b0, 32'h40, 32'h0);
        req_valid = 4'b1001;
        tick();
        total++; if (req_ready !== (4'b1 << rr_pick(4'b1001, exp_last))) begin bad++; $display("FAIL rst_mid_next got=%b exp=0001", req_ready); end
        req_valid = '0;
        tick();
        apb_done = 1'b1; apb_rdata = 32'h77;
        tick();
        apb_done = 1'b0;
        total++; if ({rsp_valid, rsp_rdata} !== {4'b0001, 32'h77}) begin bad++; $display("FAIL rst_mid_rsp got=%h exp=%h", {rsp_valid, rsp_rdata}, {4'b0001, 32'h77}); end
        tick();
        exp_last = 0;
    endtask

    task automatic test_timeout();
        int n;
        logic seen;
        set_cmd(1, 1'b0, 32'h50, 32'h0);
        req_valid = 4'b0010;
        apb_rdata = 32'hFEED_F00D;
        tick();
        req_valid = '0;
        n = 0; seen = 1'b0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (rsp_valid != 4'b0) seen = 1'b1;
        end
`ifdef APB_ARB_TIMEOUT_EN
        total++; if (n !== 8 || !seen) begin bad++; $display("FAIL to_latency got=%0d exp=8", n); end
        total++; if ({rsp_valid, timeout, rsp_err, rsp_rdata, Transfer} !== {4'b0010, 2'b11, 32'h0, 1'b0}) begin
            bad++; $display("FAIL to_rsp got=%h exp=%h", {rsp_valid, timeout, rsp_err, rsp_rdata, Transfer}, {4'b0010, 2'b11, 32'h0, 1'b0});
        end
        tick();
        total++; if ({timeout, rsp_valid} !== 5'b0) begin bad++; $display("FAIL to_pulse got=%b exp=00000", {timeout, rsp_valid}); end
        exp_last = 1;
`else
        total++; if ({seen, busy, Transfer, timeout} !== 4'b0110) begin bad++; $display("FAIL no_to_hang got=%b exp=0110", {seen, busy, Transfer, timeout}); end
        do_reset();
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_slverr();
        test_rr_all();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
